// File: rtl/puf_crp_verifier.sv
// rtl/puf_crp_verifier.sv - issues enrolled challenges to the RO PUF and scores responses by Hamming distance
// Optional capture-enrollment mode: define PUF_ENROLL_CAPTURE_EN.
module puf_crp_verifier #(
  parameter int NUM_CRP       = 8,
  parameter int HD_THRESH     = 1,
  parameter int START_TIMEOUT = 16,
  parameter int MEAS_TIMEOUT  = 10000000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             START,
  input  logic                             ENR_WE,
  input  logic [$clog2(NUM_CRP)-1:0]       ENR_ADDR,
  input  logic [6:0]                       ENR_CHAL,
  input  logic [7:0]                       ENR_RESP,
  input  logic                             ENROLL,
  output logic [7:0]                       PUF_CHALLENGE,
  input  logic [7:0]                       PUF_RESPONSE,
  input  logic                             PUF_DONE,
  output logic                             BUSY,
  output logic                             VERIFY_DONE,
  output logic                             PASS,
  output logic                             ERR_TIMEOUT,
  output logic [$clog2(NUM_CRP+1)-1:0]     FAIL_COUNT,
  output logic [$clog2(8*NUM_CRP+1)-1:0]   HD_TOTAL
);
  localparam int IW   = $clog2(NUM_CRP);
  localparam int FW   = $clog2(NUM_CRP + 1);
  localparam int HW   = $clog2(8 * NUM_CRP + 1);
  localparam int TMAX = ((MEAS_TIMEOUT > START_TIMEOUT) ? MEAS_TIMEOUT : START_TIMEOUT) > SETTLE_CYCLES ?
                        ((MEAS_TIMEOUT > START_TIMEOUT) ? MEAS_TIMEOUT : START_TIMEOUT) : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 2);
  localparam logic [TW-1:0] START_LIM  = TW'(START_TIMEOUT);
  localparam logic [TW-1:0] MEAS_LIM   = TW'(MEAS_TIMEOUT);
  localparam logic [TW-1:0] SETTLE_LIM = TW'(SETTLE_CYCLES);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_CRP - 1);
  localparam logic [3:0]    THRESH     = 4'(HD_THRESH);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_APPLY, S_WAIT_START, S_WAIT_DONE, S_SETTLE, S_COMPARE, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d, timer_inc;
  logic [7:0]          challenge_q, challenge_d;
  logic                last_parity_q, last_parity_d;
  logic                busy_q, busy_d;
  logic                verify_done_q, verify_done_d;
  logic                pass_q, pass_d;
  logic                err_timeout_q, err_timeout_d;
  logic                capture_q, capture_d;
  logic [FW-1:0]       fail_count_q, fail_count_d;
  logic [HW-1:0]       hd_total_q, hd_total_d;
  logic [NUM_CRP-1:0]  valid_q, valid_d;
  logic [6:0]          chal_q [NUM_CRP];
  logic [6:0]          chal_d [NUM_CRP];
  logic [7:0]          resp_q [NUM_CRP];
  logic [7:0]          resp_d [NUM_CRP];
  logic [3:0]          hd;
  logic [HW:0]         hd_sum;

`ifndef PUF_ENROLL_CAPTURE_EN
  logic unused_enroll;
  assign unused_enroll = ENROLL;
`endif

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  assign hd        = popcnt8(PUF_RESPONSE ^ resp_q[idx_q]);
  assign hd_sum    = {1'b0, hd_total_q} + (HW+1)'(hd);
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    challenge_d   = challenge_q;
    last_parity_d = last_parity_q;
    busy_d        = busy_q;
    verify_done_d = 1'b0;
    pass_d        = pass_q;
    err_timeout_d = err_timeout_q;
    capture_d     = capture_q;
    fail_count_d  = fail_count_q;
    hd_total_d    = hd_total_q;
    valid_d       = valid_q;
    chal_d        = chal_q;
    resp_d        = resp_q;
    unique case (state_q)
      S_IDLE: begin
        if (ENR_WE) begin
          valid_d[ENR_ADDR] = 1'b1;
          chal_d[ENR_ADDR]  = ENR_CHAL;
          resp_d[ENR_ADDR]  = ENR_RESP;
        end
        if (START) begin
          fail_count_d  = '0;
          hd_total_d    = '0;
          pass_d        = 1'b0;
          err_timeout_d = 1'b0;
          idx_d         = '0;
          busy_d        = 1'b1;
`ifdef PUF_ENROLL_CAPTURE_EN
          capture_d     = ENROLL;
`else
          capture_d     = 1'b0;
`endif
          state_d       = S_SCAN;
        end
      end
      S_SCAN: begin
        if (valid_q[idx_q])        state_d = S_APPLY;
        else if (idx_q == LAST_IDX) state_d = S_FINISH;
        else                        idx_d = idx_q + IW'(1);
      end
      S_APPLY: begin
        // Bit 7 forces the byte parity to differ from the previous apply so the PUF always restarts.
        challenge_d   = {~last_parity_q ^ (^chal_q[idx_q]), chal_q[idx_q]};
        last_parity_d = ~last_parity_q;
        timer_d       = '0;
        state_d       = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!PUF_DONE) begin
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end else if (timer_inc > START_LIM) begin
          err_timeout_d = 1'b1;
          state_d       = S_FINISH;
        end else timer_d = timer_inc;
      end
      S_WAIT_DONE: begin
        if (PUF_DONE) begin
          timer_d = '0;
          state_d = S_SETTLE;
        end else if (timer_inc > MEAS_LIM) begin
          err_timeout_d = 1'b1;
          state_d       = S_FINISH;
        end else timer_d = timer_inc;
      end
      S_SETTLE: begin
        if (timer_inc >= SETTLE_LIM) state_d = S_COMPARE;
        else                         timer_d = timer_inc;
      end
      S_COMPARE: begin
        if (capture_q) resp_d[idx_q] = PUF_RESPONSE;
        else begin
          hd_total_d = hd_sum[HW] ? '1 : hd_sum[HW-1:0];
          if (hd > THRESH && fail_count_q != '1) fail_count_d = fail_count_q + FW'(1);
        end
        if (idx_q == LAST_IDX) state_d = S_FINISH;
        else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_SCAN;
        end
      end
      S_FINISH: begin
        pass_d        = capture_q ? !err_timeout_q
                                  : (!err_timeout_q && fail_count_q == '0 && |valid_q);
        verify_done_d = 1'b1;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      challenge_q   <= '0;
      last_parity_q <= 1'b0;
      busy_q        <= 1'b0;
      verify_done_q <= 1'b0;
      pass_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      capture_q     <= 1'b0;
      fail_count_q  <= '0;
      hd_total_q    <= '0;
      valid_q       <= '0;
      for (int i = 0; i < NUM_CRP; i++) begin
        chal_q[i] <= '0;
        resp_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      challenge_q   <= challenge_d;
      last_parity_q <= last_parity_d;
      busy_q        <= busy_d;
      verify_done_q <= verify_done_d;
      pass_q        <= pass_d;
      err_timeout_q <= err_timeout_d;
      capture_q     <= capture_d;
      fail_count_q  <= fail_count_d;
      hd_total_q    <= hd_total_d;
      valid_q       <= valid_d;
      chal_q        <= chal_d;
      resp_q        <= resp_d;
    end
  end

  assign PUF_CHALLENGE = challenge_q;
  assign BUSY          = busy_q;
  assign VERIFY_DONE   = verify_done_q;
  assign PASS          = pass_q;
  assign ERR_TIMEOUT   = err_timeout_q;
  assign FAIL_COUNT    = fail_count_q;
  assign HD_TOTAL      = hd_total_q;
endmodule

// File: tb/tb_puf_crp_verifier.sv
// tb/tb_puf_crp_verifier.sv - scoreboard bench with a behavioural PUF and CRP reference model
module tb_puf_crp_verifier;
  localparam int NUM_CRP = 8, HD_THRESH = 1, START_TIMEOUT = 16, MEAS_TIMEOUT = 300, SETTLE_CYCLES = 2;

  logic       CLK = 1'b0, RESET = 1'b1, START = 1'b0, ENR_WE = 1'b0, ENROLL = 1'b0;
  logic [2:0] ENR_ADDR = '0;
  logic [6:0] ENR_CHAL = '0;
  logic [7:0] ENR_RESP = '0, PUF_RESPONSE, PUF_CHALLENGE;
  logic       PUF_DONE, BUSY, VERIFY_DONE, PASS, ERR_TIMEOUT;
  logic [3:0] FAIL_COUNT;
  logic [6:0] HD_TOTAL;

  puf_crp_verifier #(.NUM_CRP(NUM_CRP), .HD_THRESH(HD_THRESH), .START_TIMEOUT(START_TIMEOUT),
                     .MEAS_TIMEOUT(MEAS_TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ENR_WE(ENR_WE), .ENR_ADDR(ENR_ADDR),
    .ENR_CHAL(ENR_CHAL), .ENR_RESP(ENR_RESP), .ENROLL(ENROLL), .PUF_CHALLENGE(PUF_CHALLENGE),
    .PUF_RESPONSE(PUF_RESPONSE), .PUF_DONE(PUF_DONE), .BUSY(BUSY), .VERIFY_DONE(VERIFY_DONE),
    .PASS(PASS), .ERR_TIMEOUT(ERR_TIMEOUT), .FAIL_COUNT(FAIL_COUNT), .HD_TOTAL(HD_TOTAL));

  always #5 CLK = ~CLK;

  typedef struct { logic pass; logic err; int fc; int hd; } res_t;
  res_t       exp_q[$];
  logic [7:0] chal_exp_q[$];
  int         errors = 0, checks = 0;

  logic       ref_valid [NUM_CRP];
  logic [6:0] ref_chal  [NUM_CRP];
  logic [7:0] ref_resp  [NUM_CRP];
  logic [7:0] puf_resp  [128];
  int         ref_last = 0;
  bit         puf_dead = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the enrolled table in address order, toggling the applied byte's parity each time.
  function automatic void predict(bit capture);
    res_t r;
    logic [7:0] b;
    int hd;
    bit any = 0;
    r.pass = 0; r.err = 0; r.fc = 0; r.hd = 0;
    for (int i = 0; i < NUM_CRP; i++) begin
      if (ref_valid[i]) begin
        any = 1;
        b = {1'b0, ref_chal[i]};
        if (($countones(b) % 2) == ref_last) b[7] = 1'b1;
        ref_last = $countones(b) % 2;
        chal_exp_q.push_back(b);
        if (puf_dead) begin
          r.err = 1;
          break;
        end
        hd = $countones(puf_resp[ref_chal[i]] ^ ref_resp[i]);
        if (capture) ref_resp[i] = puf_resp[ref_chal[i]];
        else begin
          r.hd += hd;
          if (hd > HD_THRESH) r.fc++;
        end
      end
    end
    r.pass = capture ? !r.err : (any && !r.err && r.fc == 0);
    exp_q.push_back(r);
  endfunction

  // Behavioural PUF: starts on any parity change of CHALLENGE, DONE low then high after a random latency.
  int   m_cnt = 0, m_lat = 0;
  bit   m_busy = 0;
  logic m_last = 1'b0;
  initial begin
    PUF_DONE = 1'b1;
    PUF_RESPONSE = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        m_busy = 0; m_last = 1'b0; PUF_DONE = 1'b1;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == 2) begin
          PUF_DONE = 1'b0;
          PUF_RESPONSE = 8'($urandom);
        end
        if (m_cnt >= m_lat) begin
          PUF_DONE = 1'b1;
          PUF_RESPONSE = puf_resp[PUF_CHALLENGE[6:0]];
          m_busy = 0;
        end
      end else if ((^PUF_CHALLENGE) != m_last) begin
        m_last = ^PUF_CHALLENGE;
        if (!puf_dead) begin
          m_busy = 1; m_cnt = 0; m_lat = $urandom_range(4, 12);
        end
      end
    end
  end

  logic [7:0] mon_prev = '0;
  res_t       mon_r;
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) mon_prev = '0;
      else begin
        if (PUF_CHALLENGE != mon_prev) begin
          mon_prev = PUF_CHALLENGE;
          if (chal_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL apply_unexpected: got %0h expected none", PUF_CHALLENGE);
          end else check("apply_byte", PUF_CHALLENGE, chal_exp_q.pop_front());
        end
        if (VERIFY_DONE) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got pulse expected none");
          end else begin
            mon_r = exp_q.pop_front();
            check("pass", PASS, mon_r.pass);
            check("err_timeout", ERR_TIMEOUT, mon_r.err);
            check("fail_count", FAIL_COUNT, mon_r.fc);
            check("hd_total", HD_TOTAL, mon_r.hd);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; tick(); tick(); RESET = 1'b0;
    for (int i = 0; i < NUM_CRP; i++) ref_valid[i] = 0;
    ref_last = 0;
  endtask

  task automatic enroll(input logic [2:0] a, input logic [6:0] c, input logic [7:0] r);
    ENR_WE = 1'b1; ENR_ADDR = a; ENR_CHAL = c; ENR_RESP = r;
    tick();
    ENR_WE = 1'b0;
    ref_valid[a] = 1; ref_chal[a] = c; ref_resp[a] = r;
  endtask

  task automatic start_run(input bit cap);
    predict(cap);
    START = 1'b1; ENROLL = cap;
    tick();
    START = 1'b0; ENROLL = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    bit seen = 0;
    cycles = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge CLK);
      cycles++;
      if (VERIFY_DONE) seen = 1;
    end
    check("done_seen", seen, 1);
  endtask

  int n, tc;
  bit seen_apply, seen_done;
  logic [7:0] prev_c, mask, r8;
  logic [6:0] c7;
  logic [2:0] a3;

  initial begin
    for (int i = 0; i < 128; i++) puf_resp[i] = 8'($urandom);
    for (int i = 0; i < NUM_CRP; i++) ref_valid[i] = 0;
    tick(); tick();
    @(negedge CLK);
    check("rst_challenge", PUF_CHALLENGE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", VERIFY_DONE, 0);
    check("rst_pass", PASS, 0);
    check("rst_err", ERR_TIMEOUT, 0);
    check("rst_fail_count", FAIL_COUNT, 0);
    check("rst_hd_total", HD_TOTAL, 0);
    tick();
    RESET = 1'b0;

    // Single matching entry from reset: parity bit must be set
    enroll(3'd0, 7'h05, 8'hA5);
    puf_resp[7'h05] = 8'hA5;
    start_run(0); wait_done(n);
    check("single_challenge", PUF_CHALLENGE, 8'h85);
    check("single_pass", PASS, 1);

    // HD 0,1,2,8 across four entries
    do_reset();
    enroll(3'd0, 7'h10, 8'h5A); puf_resp[7'h10] = 8'h5A;
    enroll(3'd1, 7'h11, 8'h33); puf_resp[7'h11] = 8'h33 ^ 8'h01;
    enroll(3'd2, 7'h12, 8'hC4); puf_resp[7'h12] = 8'hC4 ^ 8'h03;
    enroll(3'd3, 7'h13, 8'h0F); puf_resp[7'h13] = 8'h0F ^ 8'hFF;
    start_run(0); wait_done(n);
    check("multi_hd_total", HD_TOTAL, 11);
    check("multi_fail_count", FAIL_COUNT, 2);
    check("multi_pass", PASS, 0);

    // Back-to-back entries; applied bytes checked against the parity rule by the monitor
    do_reset();
    enroll(3'd0, 7'h01, 8'h11); puf_resp[7'h01] = 8'h11;
    enroll(3'd1, 7'h03, 8'h22); puf_resp[7'h03] = 8'h22;
    start_run(0); wait_done(n);

    // PUF never starts: start timeout, VERIFY_DONE START_TIMEOUT+2 cycles after the apply
    do_reset();
    enroll(3'd2, 7'h40, 8'h99);
    puf_dead = 1;
    start_run(0);
    prev_c = PUF_CHALLENGE; seen_apply = 0; seen_done = 0; tc = 0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      @(negedge CLK);
      if (!seen_apply && PUF_CHALLENGE != prev_c) begin
        seen_apply = 1; tc = 0;
      end else if (seen_apply) tc++;
      if (VERIFY_DONE) seen_done = 1;
    end
    check("timeout_done_seen", seen_done, 1);
    check("timeout_latency", tc, START_TIMEOUT + 2);
    check("timeout_err", ERR_TIMEOUT, 1);
    puf_dead = 0;

    // Empty table: fast finish; writes and START while busy are ignored
    do_reset();
    start_run(0); wait_done(n);
    check("empty_latency_ok", int'(n <= NUM_CRP + 2), 1);
    start_run(0);
    tick(); tick();
    ENR_WE = 1'b1; ENR_ADDR = 3'd0; ENR_CHAL = 7'h22; ENR_RESP = 8'h44; START = 1'b1;
    tick();
    ENR_WE = 1'b0; START = 1'b0;
    wait_done(n);
    start_run(0); wait_done(n);

    // Randomized tables with overwrites and small response perturbations
    for (int r = 0; r < 8; r++) begin
      if (r % 3 == 0) do_reset();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        a3 = 3'($urandom); c7 = 7'($urandom); r8 = 8'($urandom);
        case ($urandom_range(0, 3))
          0: mask = 8'h00;
          1: mask = 8'(1 << $urandom_range(0, 7));
          2: mask = 8'(3 << $urandom_range(0, 6));
          default: mask = 8'($urandom);
        endcase
        puf_resp[c7] = r8 ^ mask;
        enroll(a3, c7, r8);
      end
      start_run(0); wait_done(n);
    end

    // Reset during measurement aborts without a done pulse and clears the table
    do_reset();
    enroll(3'd5, 7'h2B, 8'h77); puf_resp[7'h2B] = 8'h77;
    start_run(0);
    seen_apply = 0;
    for (int i = 0; i < 100 && !seen_apply; i++) begin
      @(negedge CLK);
      if (!PUF_DONE) seen_apply = 1;
    end
    check("midrun_wait_done_reached", seen_apply, 1);
    tick();
    RESET = 1'b1;
    @(negedge CLK);
    check("midrun_rst_busy", BUSY, 0);
    check("midrun_rst_challenge", PUF_CHALLENGE, 0);
    check("midrun_rst_pass", PASS, 0);
    check("midrun_rst_hd", HD_TOTAL, 0);
    void'(exp_q.pop_back());
    do_reset();
    start_run(0); wait_done(n);

`ifdef PUF_ENROLL_CAPTURE_EN
    do_reset();
    enroll(3'd1, 7'h2A, 8'h00); puf_resp[7'h2A] = 8'h3C;
    start_run(1); wait_done(n);
    check("capture_pass", PASS, 1);
    start_run(0); wait_done(n);
    check("post_capture_pass", PASS, 1);
    check("post_capture_hd", HD_TOTAL, 0);
`endif

    tick(); tick();
    check("exp_results_drained", exp_q.size(), 0);
    check("exp_applies_drained", chal_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
